dotprod_engine: RTL and testbench



---
 rtl/dotprod_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_dotprod_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotprod_engine.sv
// Multi-lane dot-product engine: streams two vectors from synchronous-read memories and
// accumulates sum(a[i]*b[i]) through a product / lane-sum / accumulate pipeline.
module dotprod_engine #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned ACC_W  = 64,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         n,
   input  logic                      signed_mode,
   input  logic [ADDR_W-1:0]         a_base,
   input  logic [ADDR_W-1:0]         b_base,
   output logic [ADDR_W-1:0]         a_addr,
   output logic                      a_rd_en,
   input  logic [LANES*DATA_W-1:0]   a_in,
   output logic [ADDR_W-1:0]         b_addr,
   output logic                      b_rd_en,
   input  logic [LANES*DATA_W-1:0]   b_in,
   output logic                      busy,
   output logic                      done,
   output logic [ACC_W-1:0]          result
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic                             start_ok;
   logic                             issue;
   logic                             last_word;
   logic [LANES-1:0]                 issue_mask;

   logic [ADDR_W-1:0]                rem_q, rem_d;
   logic [ADDR_W-1:0]                a_addr_q, a_addr_d;
   logic [ADDR_W-1:0]                b_addr_q, b_addr_d;
   logic                             signed_q, signed_d;

   logic [RD_LAT-1:0]                tag_vld_q, tag_vld_d;
   logic [RD_LAT-1:0][LANES-1:0]     tag_mask_q, tag_mask_d;

   logic                             p_vld_q, p_vld_d;
   logic [LANES-1:0][PROD_W-1:0]     p_prod_q, p_prod_d;
   logic                             s_vld_q, s_vld_d;
   logic [ACC_W-1:0]                 s_sum_q, s_sum_d;
   logic [ACC_W-1:0]                 acc_q, acc_d;
   logic [ACC_W-1:0]                 result_q, result_d;

   assign start_ok  = (state_q == StIdle) && start;
   assign issue     = (state_q == StIssue);
   // rem_q counts elements not yet issued; the final word is the one that covers the rest.
   assign last_word = (rem_q <= ADDR_W'(LANES));

   always_comb begin
      issue_mask = '0;
      for (int j = 0; j < LANES; j++) begin
         issue_mask[j] = (rem_q > ADDR_W'(j));
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (n == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            if (last_word) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // S retires into the accumulator on this edge, so A is final when DONE begins.
            if (!(|tag_vld_q) && !p_vld_q) begin
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      a_rd_en = issue;
      b_rd_en = issue;
      a_addr  = a_addr_q;
      b_addr  = b_addr_q;
      busy    = (state_q != StIdle);
      done    = (state_q == StDone);
      result  = (state_q == StDone) ? acc_q : result_q;
   end

   // ---------------------------------------------------------------- issue side
   always_comb begin
      rem_d    = rem_q;
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q;
      signed_d = signed_q;
      if (start_ok) begin
         rem_d    = n;
         signed_d = signed_mode;
         if (n != '0) begin
            a_addr_d = a_base;
            b_addr_d = b_base;
         end
      end else if (issue) begin
         if (last_word) begin
            rem_d = '0;
         end else begin
            rem_d    = rem_q - ADDR_W'(LANES);
            a_addr_d = a_addr_q + ADDR_W'(1);
            b_addr_d = b_addr_q + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      tag_vld_d     = '0;
      tag_mask_d    = '0;
      tag_vld_d[0]  = issue;
      tag_mask_d[0] = issue ? issue_mask : '0;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_mask_d[i] = tag_mask_q[i-1];
      end
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin : p_stage_comb
      logic [PROD_W-1:0] a_op;
      logic [PROD_W-1:0] b_op;
      a_op     = '0;
      b_op     = '0;
      p_vld_d  = tag_vld_q[RD_LAT-1];
      p_prod_d = '0;
      for (int j = 0; j < LANES; j++) begin
         if (signed_q) begin
            a_op = PROD_W'($signed(a_in[j*DATA_W +: DATA_W]));
            b_op = PROD_W'($signed(b_in[j*DATA_W +: DATA_W]));
         end else begin
            a_op = PROD_W'(a_in[j*DATA_W +: DATA_W]);
            b_op = PROD_W'(b_in[j*DATA_W +: DATA_W]);
         end
         if (p_vld_d && tag_mask_q[RD_LAT-1][j]) begin
            p_prod_d[j] = a_op * b_op;
         end
      end
   end

   always_comb begin
      s_vld_d = p_vld_q;
      s_sum_d = '0;
      for (int j = 0; j < LANES; j++) begin
         if (signed_q) begin
            s_sum_d = s_sum_d + ACC_W'($signed(p_prod_q[j]));
         end else begin
            s_sum_d = s_sum_d + ACC_W'(p_prod_q[j]);
         end
      end
   end

   always_comb begin
      acc_d    = acc_q;
      result_d = result_q;
      if (start_ok) begin
         acc_d = '0;
      end else if (s_vld_q) begin
         acc_d = acc_q + s_sum_q;
      end
      if (state_q == StDone) begin
         result_d = acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q      <= '0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         signed_q   <= 1'b0;
         tag_vld_q  <= '0;
         tag_mask_q <= '0;
         p_vld_q    <= 1'b0;
         p_prod_q   <= '0;
         s_vld_q    <= 1'b0;
         s_sum_q    <= '0;
         acc_q      <= '0;
         result_q   <= '0;
      end else begin
         rem_q      <= rem_d;
         a_addr_q   <= a_addr_d;
         b_addr_q   <= b_addr_d;
         signed_q   <= signed_d;
         tag_vld_q  <= tag_vld_d;
         tag_mask_q <= tag_mask_d;
         p_vld_q    <= p_vld_d;
         p_prod_q   <= p_prod_d;
         s_vld_q    <= s_vld_d;
         s_sum_q    <= s_sum_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
      end
   end

endmodule

// File: tb/tb_dotprod_engine.sv
// Bench for dotprod_engine: two instances (4 lanes / latency 2, and 1 lane / latency 1 with a
// 16-bit accumulator) fed by behavioural memories and checked against an arithmetic model.
module tb_dotprod_engine;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 16;
   localparam int unsigned L0    = 4;
   localparam int unsigned RL0   = 2;
   localparam int unsigned ACC0  = 32;
   localparam int unsigned L1    = 1;
   localparam int unsigned RL1   = 1;
   localparam int unsigned ACC1  = 16;
   localparam int          MEMSZ = 1024;

   logic clk, rst, start0, start1, sgn_in;
   logic [AW-1:0] n_in, ab_in, bb_in;
   logic [AW-1:0] a_addr0, b_addr0, a_addr1, b_addr1;
   logic a_rd0, b_rd0, a_rd1, b_rd1, busy0, busy1, done0, done1;
   logic [L0*DW-1:0] ra0_s1, ra0_s2, rb0_s1, rb0_s2;
   logic [L1*DW-1:0] ra1, rb1;
   logic [ACC0-1:0] result0;
   logic [ACC1-1:0] result1;
   logic [7:0] ma0 [MEMSZ];
   logic [7:0] mb0 [MEMSZ];
   logic [7:0] ma1 [MEMSZ];
   logic [7:0] mb1 [MEMSZ];

   int n_vec;
   int n_err;

   logic sel;
   logic m_busy, m_done, m_rda, m_rdb;
   logic [AW-1:0] m_aaddr, m_baddr;
   logic [31:0] m_result;

   dotprod_engine #(.DATA_W(DW), .LANES(L0), .ACC_W(ACC0), .ADDR_W(AW), .RD_LAT(RL0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .n(n_in), .signed_mode(sgn_in),
      .a_base(ab_in), .b_base(bb_in), .a_addr(a_addr0), .a_rd_en(a_rd0), .a_in(ra0_s2),
      .b_addr(b_addr0), .b_rd_en(b_rd0), .b_in(rb0_s2), .busy(busy0), .done(done0),
      .result(result0)
   );

   dotprod_engine #(.DATA_W(DW), .LANES(L1), .ACC_W(ACC1), .ADDR_W(AW), .RD_LAT(RL1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .n(n_in), .signed_mode(sgn_in),
      .a_base(ab_in), .b_base(bb_in), .a_addr(a_addr1), .a_rd_en(a_rd1), .a_in(ra1),
      .b_addr(b_addr1), .b_rd_en(b_rd1), .b_in(rb1), .busy(busy1), .done(done1),
      .result(result1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memories: element (word w, lane j) lives at index (w*LANES + j) mod MEMSZ.
   always @(posedge clk) begin
      for (int j = 0; j < L0; j++) begin
         ra0_s1[j*DW +: DW] <= a_rd0 ? ma0[(int'(a_addr0) * L0 + j) % MEMSZ] : 8'($urandom);
         rb0_s1[j*DW +: DW] <= b_rd0 ? mb0[(int'(b_addr0) * L0 + j) % MEMSZ] : 8'($urandom);
      end
      ra0_s2 <= ra0_s1;
      rb0_s2 <= rb0_s1;
      ra1    <= a_rd1 ? ma1[int'(a_addr1) % MEMSZ] : 8'($urandom);
      rb1    <= b_rd1 ? mb1[int'(b_addr1) % MEMSZ] : 8'($urandom);
   end

   always_comb begin
      if (sel) begin
         m_busy = busy1; m_done = done1; m_rda = a_rd1; m_rdb = b_rd1;
         m_aaddr = a_addr1; m_baddr = b_addr1; m_result = 32'(result1);
      end else begin
         m_busy = busy0; m_done = done0; m_rda = a_rd0; m_rdb = b_rd0;
         m_aaddr = a_addr0; m_baddr = b_addr0; m_result = result0;
      end
   end

   function automatic longint ref_dot(input bit s, input int nn, input bit sg, input int ab,
                                      input int bb);
      int l, ia, ib;
      longint sum, va, vb;
      logic [7:0] ea, eb;
      l   = s ? L1 : L0;
      sum = 0;
      for (int i = 0; i < nn; i++) begin
         ia = ((((ab + i / l) % 65536) * l) + i % l) % MEMSZ;
         ib = ((((bb + i / l) % 65536) * l) + i % l) % MEMSZ;
         ea = s ? ma1[ia] : ma0[ia];
         eb = s ? mb1[ib] : mb0[ib];
         va = sg ? longint'($signed(ea)) : longint'(ea);
         vb = sg ? longint'($signed(eb)) : longint'(eb);
         sum += va * vb;
      end
      return sum;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < MEMSZ; i++) begin
         ma0[i] = 8'($urandom); mb0[i] = 8'($urandom);
         ma1[i] = 8'($urandom); mb1[i] = 8'($urandom);
      end
   endtask

   // Called at a negedge; the cycle it is called in is cycle 0 of the operation.
   task automatic run_op(input bit s, input int nn, input bit sg, input int ab, input int bb,
                         input longint exp_v, input int poke, input bit b2b, input string name);
      int l, rl, w, dcyc, got_done, rds, addr_bad, busy_bad;
      logic [AW-1:0] prev_a, prev_b, ea, eb;
      logic [31:0] expv;
      sel = s;
      #1;
      prev_a = m_aaddr;
      prev_b = m_baddr;
      l    = s ? L1 : L0;
      rl   = s ? RL1 : RL0;
      w    = (nn + l - 1) / l;
      dcyc = (nn == 0) ? 1 : w + rl + 3;
      expv = 32'(exp_v) & (s ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      n_in = AW'(nn); sgn_in = sg; ab_in = AW'(ab); bb_in = AW'(bb);
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0; start1 = 1'b0;
      got_done = 0; rds = 0; addr_bad = 0; busy_bad = 0;
      for (int cyc = 1; cyc <= 200 && got_done == 0; cyc++) begin
         @(negedge clk);
         if (cyc <= w) begin
            ea = AW'(ab + cyc - 1); eb = AW'(bb + cyc - 1);
         end else if (w > 0) begin
            ea = AW'(ab + w - 1); eb = AW'(bb + w - 1);
         end else begin
            ea = prev_a; eb = prev_b;
         end
         if (m_rda !== 1'(cyc <= w) || m_rdb !== 1'(cyc <= w)) addr_bad++;
         if (m_aaddr !== ea || m_baddr !== eb) addr_bad++;
         if (m_rda === 1'b1) rds++;
         if (m_busy !== 1'b1) busy_bad++;
         if (m_done === 1'b1) got_done = cyc;
         if (poke != 0 && cyc == poke) begin
            n_in = AW'($urandom_range(1, 9)); ab_in = AW'($urandom); bb_in = AW'($urandom);
            sgn_in = ~sgn_in;
            if (s) start1 = 1'b1; else start0 = 1'b1;
         end
         if (poke != 0 && cyc == poke + 1) begin
            start0 = 1'b0; start1 = 1'b0;
         end
      end
      start0 = 1'b0; start1 = 1'b0;
      n_vec++;
      if (got_done != dcyc) begin
         n_err++; $display("FAIL %s done_cycle: got %0d want %0d", name, got_done, dcyc);
      end
      n_vec++;
      if (m_result !== expv) begin
         n_err++; $display("FAIL %s result: got %0h want %0h", name, m_result, expv);
      end
      n_vec++;
      if (rds != w) begin
         n_err++; $display("FAIL %s reads: got %0d want %0d", name, rds, w);
      end
      n_vec++;
      if (addr_bad != 0) begin
         n_err++; $display("FAIL %s addr/rd_en: %0d bad cycles, want 0", name, addr_bad);
      end
      n_vec++;
      if (busy_bad != 0) begin
         n_err++; $display("FAIL %s busy: %0d low cycles, want 0", name, busy_bad);
      end
      if (!b2b) begin
         @(negedge clk);
         n_vec++;
         if (m_done !== 1'b0 || m_busy !== 1'b0 || m_result !== expv) begin
            n_err++;
            $display("FAIL %s hold: done=%b busy=%b result=%0h want 0 0 %0h", name, m_done,
                     m_busy, m_result, expv);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         n_vec++;
         if ({m_busy, m_done, m_rda, m_rdb} !== 4'b0 || m_aaddr !== '0 || m_baddr !== '0 ||
             m_result !== '0) begin
            n_err++;
            $display("FAIL reset dut%0d: busy=%b done=%b rd=%b%b addr=%0h/%0h result=%0h want 0",
                     s, m_busy, m_done, m_rda, m_rdb, m_aaddr, m_baddr, m_result);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_basic();
      for (int i = 0; i < 4; i++) begin
         ma1[16 + i] = 8'(i + 1);
         mb1[32 + i] = 8'(i + 5);
      end
   endtask

   task automatic test_basic();
      fill_random();
      load_basic();
      run_op(1'b1, 4, 1'b0, 16'h10, 16'h20, 70, 0, 1'b0, "basic");
   endtask

   task automatic test_partial();
      fill_random();
      for (int i = 0; i < 8; i++) begin
         ma0[32 + i] = 8'(i + 1);
         mb0[64 + i] = 8'd1;
      end
      run_op(1'b0, 5, 1'b0, 8, 16, 15, 0, 1'b0, "partial");
   endtask

   task automatic test_signed();
      ma0[0] = 8'hFF; ma0[1] = 8'h80;
      mb0[16] = 8'hFF; mb0[17] = 8'h7F;
      run_op(1'b0, 2, 1'b1, 0, 4, -16255, 0, 1'b0, "signed");
      run_op(1'b0, 2, 1'b0, 0, 4, 81281, 0, 1'b0, "unsigned");
   endtask

   task automatic test_wrap();
      ma1[40] = 8'hFF; ma1[41] = 8'hFF;
      mb1[50] = 8'hFF; mb1[51] = 8'hFF;
      run_op(1'b1, 2, 1'b0, 40, 50, 64514, 0, 1'b0, "acc_wrap");
      run_op(1'b1, 0, 1'b0, 123, 456, 0, 0, 1'b0, "zero_len");
   endtask

   task automatic test_start_busy();
      fill_random();
      run_op(1'b0, 9, 1'b1, 100, 200, ref_dot(1'b0, 9, 1'b1, 100, 200), 2, 1'b0, "busy_start0");
      run_op(1'b1, 5, 1'b0, 300, 7, ref_dot(1'b1, 5, 1'b0, 300, 7), 3, 1'b0, "busy_start1");
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 6, 1'b0, 30, 40, ref_dot(1'b0, 6, 1'b0, 30, 40), 0, 1'b1, "b2b_first");
      // Start held high through the DONE cycle must not launch a new operation yet.
      n_in = AW'(3); sgn_in = 1'b1; ab_in = AW'(50); bb_in = AW'(60);
      start0 = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy0 !== 1'b0) begin
         n_err++; $display("FAIL b2b_done_start: busy=%b want 0", busy0);
      end
      run_op(1'b0, 3, 1'b1, 50, 60, ref_dot(1'b0, 3, 1'b1, 50, 60), 0, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      int nn, ab, bb, poke;
      bit s, sg;
      fill_random();
      for (int i = 0; i < 16; i++) begin
         s  = (i % 2 == 1);
         nn = $urandom_range(0, 14);
         sg = 1'($urandom_range(0, 1));
         ab = (i % 4 == 3) ? 65535 - int'($urandom_range(0, 2)) : int'($urandom_range(0, 65535));
         bb = int'($urandom_range(0, 65535));
         poke = (i % 3 == 0 && nn > 0) ? 2 : 0;
         run_op(s, nn, sg, ab, bb, ref_dot(s, nn, sg, ab, bb), poke, 1'b0, "random");
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      load_basic();
      sel = 1'b1;
      n_in = AW'(4); sgn_in = 1'b0; ab_in = AW'(16'h10); bb_in = AW'(16'h20);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_busy: busy=%b done=%b want 0 0", busy1, done1);
      end
      n_vec++;
      if (a_rd1 !== 1'b0 || b_rd1 !== 1'b0 || a_addr1 !== '0 || b_addr1 !== '0) begin
         n_err++;
         $display("FAIL rst_mid_mem: rd=%b%b addr=%0h/%0h want 0", a_rd1, b_rd1, a_addr1, b_addr1);
      end
      n_vec++;
      if (result1 !== '0) begin
         n_err++; $display("FAIL rst_mid_result: got %0h want 0", result1);
      end
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done1 === 1'b1 || busy1 === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++; $display("FAIL rst_mid_no_done: %0d active cycles, want 0", seen);
      end
      run_op(1'b1, 4, 1'b0, 16'h10, 16'h20, 70, 0, 1'b0, "after_reset");
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      n_in = '0; sgn_in = 1'b0; ab_in = '0; bb_in = '0;
      fill_random();
      @(negedge clk);
      test_reset();
      test_basic();
      test_partial();
      test_signed();
      test_wrap();
      test_start_busy();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
